// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - read-side controller for the 8-entry FIFO register bank
// Tracks occupancy from writer commits, pops the addressed entry, flags underflow.
module fifo_read_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_en,
  input  logic             wr_push,
  input  logic [WIDTH-1:0] d_in0,
  input  logic [WIDTH-1:0] d_in1,
  input  logic [WIDTH-1:0] d_in2,
  input  logic [WIDTH-1:0] d_in3,
  input  logic [WIDTH-1:0] d_in4,
  input  logic [WIDTH-1:0] d_in5,
  input  logic [WIDTH-1:0] d_in6,
  input  logic [WIDTH-1:0] d_in7,
  output logic [WIDTH-1:0] d_out,
  output logic             rd_ack,
  output logic             rd_err,
  output logic             empty,
  output logic             full,
  output logic [3:0]       data_count,
  output logic [2:0]       rd_ptr
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READ     = 2'd1,
    RD_ERROR = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic [3:0]       count_q, count_d;
  logic [2:0]       rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] sel_data;
  logic             pop;

  always_comb begin
    sel_data = d_in0;
    case (rd_ptr_q)
      3'd0: sel_data = d_in0;
      3'd1: sel_data = d_in1;
      3'd2: sel_data = d_in2;
      3'd3: sel_data = d_in3;
      3'd4: sel_data = d_in4;
      3'd5: sel_data = d_in5;
      3'd6: sel_data = d_in6;
      3'd7: sel_data = d_in7;
      default: sel_data = d_in0;
    endcase
  end

  // A push on the same edge as an underflow is not yet visible, so pop only
  // looks at the registered count.
  always_comb begin
    pop      = rd_en && (count_q != 4'd0);
    state_d  = IDLE;
    d_out_d  = d_out_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (rd_en) begin
      state_d = pop ? READ : RD_ERROR;
    end
    if (pop) begin
      d_out_d  = sel_data;
      rd_ptr_d = rd_ptr_q + 3'd1;
    end
    case ({wr_push, pop})
      2'b10:   count_d = (count_q == 4'd8) ? count_q : count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      d_out_q  <= '0;
      count_q  <= 4'd0;
      rd_ptr_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      d_out_q  <= d_out_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign d_out      = d_out_q;
  assign rd_ack     = (state_q == READ);
  assign rd_err     = (state_q == RD_ERROR);
  assign empty      = (count_q == 4'd0);
  assign full       = (count_q == 4'd8);
  assign data_count = count_q;
  assign rd_ptr     = rd_ptr_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb/tb_fifo_read_ctrl.sv - scoreboard bench for fifo_read_ctrl
// Reference model is a plain data queue; the bench plays the writer and owns the bank.
module tb_fifo_read_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en;
  logic        wr_push;
  logic [31:0] bank [8];
  logic [31:0] d_out;
  logic        rd_ack, rd_err, empty, full;
  logic [3:0]  data_count;
  logic [2:0]  rd_ptr;

  always #5 clk = ~clk;

  fifo_read_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .wr_push(wr_push),
    .d_in0(bank[0]), .d_in1(bank[1]), .d_in2(bank[2]), .d_in3(bank[3]),
    .d_in4(bank[4]), .d_in5(bank[5]), .d_in6(bank[6]), .d_in7(bank[7]),
    .d_out(d_out), .rd_ack(rd_ack), .rd_err(rd_err), .empty(empty), .full(full),
    .data_count(data_count), .rd_ptr(rd_ptr)
  );

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dout;
    int          cnt;
    int          ptr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mq[$];
  logic [31:0] last_dout;
  int          pops;
  int          wptr;
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    pops      = 0;
    wptr      = 0;
    last_dout = '0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " d_out"}, d_out, 32'h0);
    chk({tag, " rd_ack"}, {31'b0, rd_ack}, 32'h0);
    chk({tag, " rd_err"}, {31'b0, rd_err}, 32'h0);
    chk({tag, " empty"}, {31'b0, empty}, 32'h1);
    chk({tag, " full"}, {31'b0, full}, 32'h0);
    chk({tag, " data_count"}, {28'b0, data_count}, 32'h0);
    chk({tag, " rd_ptr"}, {29'b0, rd_ptr}, 32'h0);
  endtask

  // One clock of stimulus; the writer commits its bank entry just after the edge.
  task automatic step(input logic rd, input logic push, input logic [31:0] v);
    exp_t e;
    logic do_wr;
    int   slot;
    @(negedge clk);
    rd_en   = rd;
    wr_push = push;
    e.ack = rd && (mq.size() > 0);
    e.err = rd && (mq.size() == 0);
    if (e.ack) begin
      last_dout = mq.pop_front();
      pops++;
    end
    do_wr = 1'b0;
    slot  = 0;
    if (push && mq.size() < 8) begin
      mq.push_back(v);
      do_wr = 1'b1;
      slot  = wptr;
      wptr  = (wptr + 1) % 8;
    end
    e.dout = last_dout;
    e.cnt  = mq.size();
    e.ptr  = pops % 8;
    @(posedge clk);
    #1;
    if (do_wr) bank[slot] = v;
    exp_q.push_back(e);
    rd_en   = 1'b0;
    wr_push = 1'b0;
  endtask

  task automatic reset_mid(input logic hold_rd, input string tag);
    @(negedge clk);
    rd_en = hold_rd;
    #2 reset = 1'b1;
    #1 check_reset_values(tag);
    rd_en = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_ack", {31'b0, rd_ack}, {31'b0, e.ack});
        chk("rd_err", {31'b0, rd_err}, {31'b0, e.err});
        chk("d_out", d_out, e.dout);
        chk("data_count", {28'b0, data_count}, e.cnt);
        chk("rd_ptr", {29'b0, rd_ptr}, e.ptr);
        chk("empty", {31'b0, empty}, {31'b0, e.cnt == 0});
        chk("full", {31'b0, full}, {31'b0, e.cnt == 8});
      end
    end
  end

  initial begin : stim
    reset   = 1'b1;
    rd_en   = 1'b0;
    wr_push = 1'b0;
    for (int i = 0; i < 8; i++) bank[i] = '0;
    model_clear();
    #3 check_reset_values("por");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'hA0 + i);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'hA3);

    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 32'hB0 + i);
    step(1'b0, 1'b1, 32'hDEAD);
    step(1'b1, 1'b1, 32'hC0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 32'h0);

    reset_mid(1'b0, "mid");
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, $urandom);
      step(1'b1, 1'b0, 32'h0);
    end

    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 32'hE0 + i);
    step(1'b1, 1'b0, 32'h0);
    reset_mid(1'b1, "stream");
    step(1'b0, 1'b1, 32'h5A5A5A5A);
    step(1'b1, 1'b0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      if (i < 200) step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 70, $urandom);
      else         step($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 35, $urandom);
    end

    @(negedge clk);
    #1;
    chk("scoreboard drained", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
